// File: rtl/ccg_truth_table_reader.sv
// Sweeps every input vector of a generated combinational circuit, captures the
// responses, compacts them into a MISR signature and streams the table out.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             single-cycle sweep request (honoured in IDLE only)
//   stim   [N_IN]     vector driven to the circuit under test
//   resp   [N_OUT]    circuit response, combinational in stim
//   busy, done        sweep/stream activity, one-cycle completion pulse
//   signature [N_OUT] MISR result, held from done until the next start
//   m_valid/m_ready   stream handshake
//   m_data [N_OUT]    captured response for m_index
//   m_index [N_IN]    input vector that m_data belongs to
module ccg_truth_table_reader #(
  parameter int N_IN   = 3,
  parameter int N_OUT  = 8,
  parameter int SETTLE = 1,
  parameter logic [N_OUT-1:0] POLY = N_OUT'(8'h1D)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [N_IN-1:0]  stim,
  input  logic [N_OUT-1:0] resp,
  output logic             busy,
  output logic             done,
  output logic [N_OUT-1:0] signature,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [N_OUT-1:0] m_data,
  output logic [N_IN-1:0]  m_index
);

  localparam int DEPTH = 2 ** N_IN;
  localparam logic [N_IN-1:0] LAST = N_IN'(DEPTH - 1);
  localparam logic [3:0] HOLD_LAST = 4'(SETTLE);

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    STREAM,
    FIN
  } state_t;

  state_t           r_state;
  logic [N_IN-1:0]  r_idx;
  logic [N_IN-1:0]  r_ptr;
  logic [3:0]       r_hold;
  logic [N_OUT-1:0] r_sig;
  logic [N_OUT-1:0] r_mdata;
  logic             r_mvalid;
  logic             r_busy;
  logic             r_done;
  logic [N_OUT-1:0] r_buf [DEPTH];

  logic             w_cap;
  logic [N_IN-1:0]  w_ptr_nx;
  logic [N_OUT-1:0] w_sig_nx;

  assign w_cap    = (r_state == APPLY) && (r_hold == HOLD_LAST);
  assign w_ptr_nx = r_ptr + N_IN'(1);
  assign w_sig_nx = {r_sig[N_OUT-2:0], 1'b0}
                  ^ (r_sig[N_OUT-1] ? POLY : '0)
                  ^ resp;

  assign stim      = r_idx;
  assign busy      = r_busy;
  assign done      = r_done;
  assign signature = r_sig;
  assign m_valid   = r_mvalid;
  assign m_data    = r_mdata;
  assign m_index   = r_ptr;

  // Capture buffer needs no reset; it is always rewritten before streaming.
  always_ff @(posedge clk) begin
    if (w_cap) r_buf[r_idx] <= resp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_ptr    <= '0;
      r_hold   <= '0;
      r_sig    <= '0;
      r_mdata  <= '0;
      r_mvalid <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_idx   <= '0;
            r_sig   <= '0;
            r_hold  <= '0;
            r_busy  <= 1'b1;
            r_state <= APPLY;
          end
        end
        APPLY: begin
          if (w_cap) begin
            r_sig  <= w_sig_nx;
            r_hold <= '0;
            // Terminal compare first: idx never wraps inside a sweep.
            if (r_idx == LAST) begin
              r_ptr    <= '0;
              r_mdata  <= r_buf[0];
              r_mvalid <= 1'b1;
              r_state  <= STREAM;
            end else begin
              r_idx <= r_idx + N_IN'(1);
            end
          end else begin
            r_hold <= r_hold + 4'd1;
          end
        end
        STREAM: begin
          if (m_ready) begin
            if (r_ptr == LAST) begin
              r_mvalid <= 1'b0;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= FIN;
            end else begin
              r_ptr   <= w_ptr_nx;
              r_mdata <= r_buf[w_ptr_nx];
            end
          end
        end
        FIN: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccg_truth_table_reader.sv
// Randomised bench for ccg_truth_table_reader: two instances (SETTLE=1 and
// SETTLE=0) exercised against a table-driven reference model.
module tb_ccg_truth_table_reader;

  logic       clk;
  logic       rst_n;
  logic       st  [2];
  logic       mr  [2];
  logic [2:0] so  [2];
  logic [7:0] rsp [2];
  logic       bsy [2];
  logic       dn  [2];
  logic [7:0] sg  [2];
  logic       mv  [2];
  logic [7:0] md  [2];
  logic [2:0] mi  [2];

  logic [7:0] tbl [8];

  int n_cmp;
  int n_err;

  assign rsp[0] = tbl[so[0]];
  assign rsp[1] = tbl[so[1]];

  ccg_truth_table_reader #(
    .N_IN(3), .N_OUT(8), .SETTLE(0), .POLY(8'h1D)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .stim(so[0]),
    .resp(rsp[0]), .busy(bsy[0]), .done(dn[0]),
    .signature(sg[0]), .m_valid(mv[0]), .m_ready(mr[0]),
    .m_data(md[0]), .m_index(mi[0])
  );

  ccg_truth_table_reader #(
    .N_IN(3), .N_OUT(8), .SETTLE(1), .POLY(8'h1D)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .stim(so[1]),
    .resp(rsp[1]), .busy(bsy[1]), .done(dn[1]),
    .signature(sg[1]), .m_valid(mv[1]), .m_ready(mr[1]),
    .m_data(md[1]), .m_index(mi[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // MISR over the table in ascending vector order.
  function automatic logic [7:0] model_sig();
    int s;
    s = 0;
    for (int v = 0; v < 8; v++) begin
      s = ((s * 2) % 256) ^ ((s >= 128) ? 'h1D : 0) ^ int'(tbl[v]);
    end
    return 8'(s);
  endfunction

  task automatic set_tbl(input int mode);
    for (int v = 0; v < 8; v++) begin
      case (mode)
        0:       tbl[v] = 8'(v);
        1:       tbl[v] = 8'hFF;
        default: tbl[v] = 8'($urandom_range(0, 255));
      endcase
    end
  endtask

  // rmode: 0 always ready, 1 pattern 1,0,0,1, 2 random ready.
  task automatic run_sweep(input int w, input int rmode, input bit spam);
    int per;
    int n;
    int cyc;
    int ph;
    bit r;
    bit stall;
    logic [7:0] es;
    logic [7:0] pd;
    logic [2:0] pi;
    per   = (w == 1) ? 2 : 1;
    es    = model_sig();
    n     = 0;
    ph    = 0;
    stall = 0;
    pd    = '0;
    pi    = '0;
    @(negedge clk);
    st[w] = 1'b1;
    mr[w] = 1'b0;
    @(negedge clk);
    st[w] = 1'b0;
    for (int c = 0; c < 8 * per; c++) begin
      chk("stim", 32'(so[w]), 32'(c / per));
      if (c == 0) begin
        chk("sig_clr", 32'(sg[w]), 0);
        chk("busy_on", 32'(bsy[w]), 1);
      end
      chk("mv_apply", 32'(mv[w]), 0);
      if (spam) st[w] = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    st[w] = 1'b0;
    cyc = 8 * per;
    while (n < 8 && cyc < 8 * per + 400) begin
      chk("no_early_done", 32'(dn[w]), 0);
      if (stall) begin
        chk("stall_data", 32'(md[w]), 32'(pd));
        chk("stall_idx", 32'(mi[w]), 32'(pi));
      end
      case (rmode)
        0:       r = 1'b1;
        1:       r = (ph % 4 == 0) || (ph % 4 == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      ph++;
      mr[w] = r;
      if (mv[w]) begin
        if (r) begin
          chk("idx", 32'(mi[w]), 32'(n));
          chk("data", 32'(md[w]), 32'(tbl[n]));
          n++;
          stall = 0;
        end else begin
          stall = 1;
          pd = md[w];
          pi = mi[w];
        end
      end else begin
        chk("mv_stream", 32'(mv[w]), 1);
      end
      if (spam) st[w] = 1'($urandom_range(0, 1));
      @(negedge clk);
      cyc++;
    end
    chk("xfers", 32'(n), 8);
    mr[w] = 1'b0;
    st[w] = 1'b0;
    chk("done", 32'(dn[w]), 1);
    chk("mv_fin", 32'(mv[w]), 0);
    chk("busy_fin", 32'(bsy[w]), 0);
    chk("sig", 32'(sg[w]), 32'(es));
    if (rmode == 0) chk("latency", 32'(cyc), 32'(8 * per + 8));
    if (spam) st[w] = 1'b1;
    @(negedge clk);
    st[w] = 1'b0;
    chk("done_pulse", 32'(dn[w]), 0);
    chk("idle", 32'(bsy[w]), 0);
    chk("sig_hold", 32'(sg[w]), 32'(es));
    chk("stim_last", 32'(so[w]), 7);
    @(negedge clk);
    chk("idle2", 32'(bsy[w]), 0);
  endtask

  task automatic chk_zero(input int w);
    chk("rst_stim", 32'(so[w]), 0);
    chk("rst_sig", 32'(sg[w]), 0);
    chk("rst_mv", 32'(mv[w]), 0);
    chk("rst_busy", 32'(bsy[w]), 0);
    chk("rst_done", 32'(dn[w]), 0);
    chk("rst_mdata", 32'(md[w]), 0);
    chk("rst_midx", 32'(mi[w]), 0);
  endtask

  initial begin
    int k;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    for (int w = 0; w < 2; w++) begin
      st[w] = 1'b0;
      mr[w] = 1'b0;
    end
    set_tbl(0);
    repeat (3) @(negedge clk);
    chk_zero(0);
    chk_zero(1);
    rst_n = 1'b1;
    @(negedge clk);

    set_tbl(0);
    run_sweep(1, 0, 0);
    chk("sig_identity", 32'(sg[1]), 32'h0F);

    set_tbl(1);
    run_sweep(1, 0, 0);
    chk("sig_const", 32'(sg[1]), 32'hE2);

    set_tbl(0);
    run_sweep(1, 1, 0);
    chk("sig_bp", 32'(sg[1]), 32'h0F);

    run_sweep(0, 0, 0);
    chk("sig_settle0", 32'(sg[0]), 32'h0F);

    // Abort at vector 4 with an asynchronous reset.
    set_tbl(0);
    @(negedge clk);
    st[1] = 1'b1;
    @(negedge clk);
    st[1] = 1'b0;
    k = 0;
    while (so[1] != 3'd4 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("reach_v4", 32'(so[1]), 4);
    #2 rst_n = 1'b0;
    #1 chk_zero(1);
    @(negedge clk);
    rst_n = 1'b1;
    chk_zero(1);
    run_sweep(1, 0, 0);
    chk("sig_after_rst", 32'(sg[1]), 32'h0F);

    set_tbl(2);
    run_sweep(1, 2, 1);
    set_tbl(2);
    run_sweep(0, 2, 1);

    for (int t = 0; t < 4; t++) begin
      set_tbl(2);
      run_sweep(t % 2, 2, t[1]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
